muldiv_arbiter: RTL

Two-port arbiter that shares the single iterative MulDiv unit between two requesters, such as the integer pipeline and a coprocessor/second issue port. It grants one operation at a time with round-robin priority and routes the response back to the port that issued it. It also forwards kill only from the owning requester and keeps a busy-cycle performance counter. It sits between the requesters and MulDiv and adds no latency on either the request or the response path.

---
 rtl/muldiv_arbiter_pkg.sv | 31 +++
 rtl/muldiv_arbiter_rr_arb2.sv | 30 +++
 rtl/muldiv_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/muldiv_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_arbiter_pkg
// Purpose  : Shared definitions for the MulDiv arbiter and MulDiv users.
//            Holds the arbiter state encoding, the default operand and tag
//            widths, and the MulDiv function codes.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package muldiv_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int C_XLEN  = 32;
  localparam int C_TAG_W = 5;

  // MulDiv function codes
  localparam logic [3:0] C_FN_MUL    = 4'd0;
  localparam logic [3:0] C_FN_MULH   = 4'd1;
  localparam logic [3:0] C_FN_MULHSU = 4'd2;
  localparam logic [3:0] C_FN_MULHU  = 4'd3;
  localparam logic [3:0] C_FN_DIV    = 4'd4;
  localparam logic [3:0] C_FN_DIVU   = 4'd5;
  localparam logic [3:0] C_FN_REM    = 4'd6;
  localparam logic [3:0] C_FN_REMU   = 4'd7;

endpackage
`default_nettype wire

// File: rtl/muldiv_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin winner selection. A lone valid input wins;
//            on a tie the input named by i_prio wins.
// Ports    : i_valid  [1:0] request valids (bit N = port N)
//            i_prio         port favoured on a tie
//            o_winner       selected port (0 when nothing is valid)
//            o_any          at least one input is valid
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_prio,
  output logic       o_winner,
  output logic       o_any
);

  always_comb begin
    o_any    = |i_valid;
    o_winner = 1'b0;
    case (i_valid)
      2'b10:   o_winner = 1'b1;
      2'b11:   o_winner = i_prio;
      default: o_winner = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_arbiter
// Purpose  : Shares one iterative MulDiv unit between two requesters. Grants
//            one operation at a time with round-robin priority, routes the
//            response back to the issuing port, forwards kill only from the
//            owner, and counts BUSY cycles (saturating). Request and response
//            paths are purely combinational.
// Ports    : clk, reset                 clock, synchronous active-high reset
//            rN_req_*  (N=0,1)          requester request channel
//            rN_kill                    abort this port's in-flight op
//            rN_resp_*                  requester response channel
//            md_req_*, md_kill          request/kill toward MulDiv
//            md_resp_*                  response from MulDiv
//            busy_cycles                saturating BUSY cycle counter
// Revision : 1.0  initial release
// ============================================================================
module muldiv_arbiter
  import muldiv_arbiter_pkg::*;
#(
  parameter int XLEN  = C_XLEN,
  parameter int TAG_W = C_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  // port 0
  input  logic             r0_req_valid,
  output logic             r0_req_ready,
  input  logic [3:0]       r0_req_fn,
  input  logic             r0_req_dw,
  input  logic [XLEN-1:0]  r0_req_in1,
  input  logic [XLEN-1:0]  r0_req_in2,
  input  logic [TAG_W-1:0] r0_req_tag,
  input  logic             r0_kill,
  output logic             r0_resp_valid,
  input  logic             r0_resp_ready,
  output logic [XLEN-1:0]  r0_resp_data,
  output logic [TAG_W-1:0] r0_resp_tag,
  // port 1
  input  logic             r1_req_valid,
  output logic             r1_req_ready,
  input  logic [3:0]       r1_req_fn,
  input  logic             r1_req_dw,
  input  logic [XLEN-1:0]  r1_req_in1,
  input  logic [XLEN-1:0]  r1_req_in2,
  input  logic [TAG_W-1:0] r1_req_tag,
  input  logic             r1_kill,
  output logic             r1_resp_valid,
  input  logic             r1_resp_ready,
  output logic [XLEN-1:0]  r1_resp_data,
  output logic [TAG_W-1:0] r1_resp_tag,
  // MulDiv side
  output logic             md_req_valid,
  input  logic             md_req_ready,
  output logic [3:0]       md_req_fn,
  output logic             md_req_dw,
  output logic [XLEN-1:0]  md_req_in1,
  output logic [XLEN-1:0]  md_req_in2,
  output logic [TAG_W-1:0] md_req_tag,
  output logic             md_kill,
  input  logic             md_resp_valid,
  output logic             md_resp_ready,
  input  logic [XLEN-1:0]  md_resp_data,
  input  logic [TAG_W-1:0] md_resp_tag,
  output logic [31:0]      busy_cycles
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_owner;
  logic        r_prio;
  logic [31:0] r_busy_cycles;

  logic        w_winner;
  logic        w_any;
  logic        w_req_fire;

  rr_arb2 u_rr_arb2 (
    .i_valid  ({r1_req_valid, r0_req_valid}),
    .i_prio   (r_prio),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Response payload goes to both ports; only resp_valid qualifies it.
  assign r0_resp_data = md_resp_data;
  assign r0_resp_tag  = md_resp_tag;
  assign r1_resp_data = md_resp_data;
  assign r1_resp_tag  = md_resp_tag;

  assign w_req_fire  = (r_state == ST_IDLE) && w_any && md_req_ready;
  assign busy_cycles = r_busy_cycles;

  always_comb begin
    w_state_nxt   = r_state;
    md_req_valid  = 1'b0;
    md_req_fn     = w_winner ? r1_req_fn  : r0_req_fn;
    md_req_dw     = w_winner ? r1_req_dw  : r0_req_dw;
    md_req_in1    = w_winner ? r1_req_in1 : r0_req_in1;
    md_req_in2    = w_winner ? r1_req_in2 : r0_req_in2;
    md_req_tag    = w_winner ? r1_req_tag : r0_req_tag;
    r0_req_ready  = 1'b0;
    r1_req_ready  = 1'b0;
    r0_resp_valid = 1'b0;
    r1_resp_valid = 1'b0;
    md_resp_ready = 1'b0;
    md_kill       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        md_req_valid = w_any;
        if (w_winner) r1_req_ready = md_req_ready;
        else          r0_req_ready = md_req_ready;
        if (w_req_fire) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        md_kill       = r_owner ? r1_kill       : r0_kill;
        md_resp_ready = r_owner ? r1_resp_ready : r0_resp_ready;
        // A response coinciding with the owner's kill is dropped.
        if (r_owner) r1_resp_valid = md_resp_valid && !md_kill;
        else         r0_resp_valid = md_resp_valid && !md_kill;
        if (md_kill || (md_resp_valid && md_resp_ready)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner       <= 1'b0;
      r_prio        <= 1'b0;
      r_busy_cycles <= 32'd0;
    end else begin
      if (w_req_fire) begin
        r_owner <= w_winner;
        r_prio  <= ~w_winner;
      end
      if ((r_state == ST_BUSY) && (r_busy_cycles != 32'hFFFF_FFFF))
        r_busy_cycles <= r_busy_cycles + 32'd1;
    end
  end

endmodule
`default_nettype wire
